// File: rtl/apb_wait_memory_if.sv
// APB4 slave-side bus bundle for apb_wait_memory.
// Signals: s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb (master -> slave);
//          s_prdata, s_pready, s_pslverr (slave -> master).
interface apb_wait_memory_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      s_psel;
  logic                      s_penable;
  logic                      s_pwrite;
  logic [ADDR_WIDTH-1:0]     s_paddr;
  logic [DATA_WIDTH-1:0]     s_pwdata;
  logic [DATA_WIDTH/8-1:0]   s_pstrb;
  logic [DATA_WIDTH-1:0]     s_prdata;
  logic                      s_pready;
  logic                      s_pslverr;

  modport master (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
    input  s_prdata, s_pready, s_pslverr
  );

  modport slave (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
    output s_prdata, s_pready, s_pslverr
  );
endinterface

// File: rtl/apb_wait_memory.sv
// APB4 slave memory with programmable read/write wait states, byte-strobe
// writes, range/alignment error reporting and registered responses.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - apb_wait_memory_if.slave (s_psel/s_penable/s_pwrite/s_paddr/
//          s_pwdata/s_pstrb in; s_prdata/s_pready/s_pslverr out, registered)
// Optional feature: define APB_WAIT_MEMORY_ID_TAG_EN to replace the top byte
// of read data with ID[7:0].
module apb_wait_memory #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 0,
  parameter int unsigned ID         = 0
) (
  input logic               clk,
  input logic               rst,
  apb_wait_memory_if.slave  bus
);

  localparam int unsigned BL     = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(BL);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [3:0]  RD_N   = 4'(RD_WAIT);
  localparam logic [3:0]  WR_N   = 4'(WR_WAIT);
  localparam logic [7:0]  ID_BYTE = 8'(ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]  word_addr;
  logic                   setup;
  logic                   setup_err;
  logic [IDX_W-1:0]       setup_idx;
  logic [3:0]             wait_n;
  logic                   acc_write;
  logic                   acc_err;
  logic [IDX_W-1:0]       acc_idx;
  logic [DATA_WIDTH-1:0]  ack_data;
  logic                   go_ack;
  logic                   mem_we;

  // Setup-phase address decode: word index, range and alignment errors.
  assign word_addr = bus.s_paddr >> OFFS_W;
  assign setup     = bus.s_psel & ~bus.s_penable;
  assign setup_err = (word_addr >= ADDR_WIDTH'(MEM_DEPTH)) ||
                     ((bus.s_paddr & ADDR_WIDTH'(BL - 1)) != '0);
  assign setup_idx = word_addr[IDX_W-1:0];
  assign wait_n    = bus.s_pwrite ? WR_N : RD_N;

  // ACK can be entered straight from IDLE, so use live decode there.
  assign acc_write = (state_q == ST_IDLE) ? bus.s_pwrite : write_q;
  assign acc_err   = (state_q == ST_IDLE) ? setup_err    : err_q;
  assign acc_idx   = (state_q == ST_IDLE) ? setup_idx    : idx_q;

  // Response data captured on entry to ACK.
  always_comb begin
    ack_data = '0;
    if (!acc_write && !acc_err) begin
      ack_data = mem[acc_idx];
    end
`ifdef APB_WAIT_MEMORY_ID_TAG_EN
    if (!acc_write) begin
      ack_data[DATA_WIDTH-1 -: 8] = ID_BYTE;
    end
`endif
  end

`ifndef APB_WAIT_MEMORY_ID_TAG_EN
  logic unused_id;
  assign unused_id = ^ID_BYTE;
`endif

  // Next-state and response logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    go_ack    = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          write_d = bus.s_pwrite;
          idx_d   = setup_idx;
          err_d   = setup_err;
          if (wait_n == 4'd0) begin
            go_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_n - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.s_psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          go_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        mem_we  = bus.s_psel & bus.s_penable & write_q & ~err_q & ~rst;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_ack) begin
      state_d   = ST_ACK;
      prdata_d  = ack_data;
      pready_d  = 1'b1;
      pslverr_d = acc_err;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Byte-strobed write at the edge closing ACK; array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(BL); i++) begin
        if (bus.s_pstrb[i]) begin
          mem[idx_q][8*i +: 8] <= bus.s_pwdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.s_prdata  = prdata_q;
  assign bus.s_pready  = pready_q;
  assign bus.s_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_wait_memory.sv
// Self-checking bench for apb_wait_memory: two instances (default timing and
// RD_WAIT=3/WR_WAIT=2), directed vector table, multi-cycle corner sequences
// and randomized traffic against a word-array reference model.
module tb_apb_wait_memory;

  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];

  apb_wait_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb_wait_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

  assign b0.s_psel = psel[0];    assign b1.s_psel = psel[1];
  assign b0.s_penable = penable[0]; assign b1.s_penable = penable[1];
  assign b0.s_pwrite = pwrite[0];  assign b1.s_pwrite = pwrite[1];
  assign b0.s_paddr = paddr[0];    assign b1.s_paddr = paddr[1];
  assign b0.s_pwdata = pwdata[0];  assign b1.s_pwdata = pwdata[1];
  assign b0.s_pstrb = pstrb[0];    assign b1.s_pstrb = pstrb[1];

  apb_wait_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                    .RD_WAIT(1), .WR_WAIT(0), .ID(8'h5A))
    dut0 (.clk(clk), .rst(rst), .bus(b0));

  apb_wait_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                    .RD_WAIT(3), .WR_WAIT(2), .ID(8'h5A))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  int rd_wait [2] = '{1, 3};
  int wr_wait [2] = '{0, 2};

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl [2][DEPTH];

  function automatic logic rdy(input int d);
    return (d == 1) ? b1.s_pready : b0.s_pready;
  endfunction
  function automatic logic serr(input int d);
    return (d == 1) ? b1.s_pslverr : b0.s_pslverr;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 1) ? b1.s_prdata : b0.s_prdata;
  endfunction

  function automatic logic [31:0] tag(input logic [31:0] v);
    logic [31:0] r;
    r = v;
`ifdef APB_WAIT_MEMORY_ID_TAG_EN
    r[31:24] = 8'h5A;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: the word array plus the address/latency rules.
  task automatic model(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] erd, output logic eerr, output int elat);
    logic [31:0] a;
    int unsigned w;
    a = addr;
    w = a >> 2;
    eerr = (w >= DEPTH) || (a[1:0] != 2'b00);
    elat = 1 + (wr ? wr_wait[d] : rd_wait[d]);
    erd  = 32'h0;
    if (wr) begin
      if (!eerr)
        for (int i = 0; i < 4; i++)
          if (strb[i]) mdl[d][w][8*i +: 8] = wdata[8*i +: 8];
    end else begin
      erd = eerr ? 32'h0 : mdl[d][w];
      erd = tag(erd);
    end
  endtask

  // One complete APB transfer; starts and ends just after a falling edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int lat);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(negedge clk);
    penable[d] = 1'b1;
    lat = 1;
    while (!rdy(d) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd  = rdat(d);
    err = serr(d);
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("pready_single_cycle", 32'(rdy(d)), 32'h0);
    chk("pslverr_outside_ack", 32'(serr(d)), 32'h0);
    chk("prdata_hold", rdat(d), rd);
  endtask

  task automatic check_idle(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_pready"},  32'(rdy(d)),  32'h0);
      chk({nm, "_pslverr"}, 32'(serr(d)), 32'h0);
      chk({nm, "_prdata"},  rdat(d),      32'h0);
    end
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rd;
    bit          err;
    int          lat;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat, elat;

    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = 32'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0;
    end

    tbl.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0,        1'b0, 1});
    tbl.push_back('{0, 1'b0, 32'h10,  32'hFFFFFFFF, 4'hF, 32'hDE22BE44, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        1'b1, 2});
    tbl.push_back('{0, 1'b1, 32'h102, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 1});
    tbl.push_back('{0, 1'b1, 32'h12,  32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 1});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 32'hFC,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 1});
    tbl.push_back('{0, 1'b1, 32'hFC,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1});
    tbl.push_back('{0, 1'b0, 32'hFC,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h101, 32'h0,        4'h0, 32'h0,        1'b1, 2});
    tbl.push_back('{1, 1'b1, 32'h20,  32'h12345678, 4'hF, 32'h0,        1'b0, 3});
    tbl.push_back('{1, 1'b1, 32'h20,  32'hAABBCCDD, 4'hC, 32'h0,        1'b0, 3});
    tbl.push_back('{1, 1'b0, 32'h20,  32'h0,        4'h0, 32'hAABB5678, 1'b0, 4});
    tbl.push_back('{1, 1'b0, 32'h103, 32'h0,        4'h0, 32'h0,        1'b1, 4});

    // Reset and idle: outputs stay at zero.
    repeat (3) begin @(negedge clk); check_idle("reset"); end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); check_idle("idle"); end

    // Give every word a known value.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < int'(DEPTH); w++) begin
        logic [31:0] v;
        v = $urandom;
        model(d, 1'b1, 32'(w * 4), v, 4'hF, erd, eerr, elat);
        xfer(d, 1'b1, 32'(w * 4), v, 4'hF, rd, err, lat);
        chk("init_err", 32'(err), 32'(eerr));
        chk("init_lat", 32'(lat), 32'(elat));
      end

    // Directed vectors with hand-computed expectations.
    foreach (tbl[i]) begin
      model(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, erd, eerr, elat);
      xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].wr ? tbl[i].rd : tag(tbl[i].rd));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Abort in WAIT (RD_WAIT=3): drop psel in T2, new setup in T3.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h20;
    @(negedge clk); penable[1] = 1'b1;
    chk("abort_t1_pready", 32'(rdy(1)), 32'h0);
    @(negedge clk); psel[1] = 1'b0; penable[1] = 1'b0;
    chk("abort_t2_pready", 32'(rdy(1)), 32'h0);
    @(negedge clk);
    chk("abort_t3_pready", 32'(rdy(1)), 32'h0);
    model(1, 1'b0, 32'h20, 32'h0, 4'h0, erd, eerr, elat);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat);
    chk("after_abort_rdata", rd, erd);
    chk("after_abort_lat", 32'(lat), 32'(elat));

    // Abort in ACK on a zero-wait write: memory must not change.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h44; pwdata[0] = 32'h0BADF00D; pstrb[0] = 4'hF;
    @(negedge clk);
    chk("ack_abort_pready", 32'(rdy(0)), 32'h1);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    chk("ack_abort_cleared", 32'(rdy(0)), 32'h0);
    model(0, 1'b0, 32'h44, 32'h0, 4'h0, erd, eerr, elat);
    xfer(0, 1'b0, 32'h44, 32'h0, 4'h0, rd, err, lat);
    chk("ack_abort_mem", rd, erd);

    // Reset in the middle of a WAIT-state write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h40; pwdata[1] = 32'h600DCAFE; pstrb[1] = 4'hF;
    @(negedge clk); penable[1] = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    check_idle("midrst");
    @(negedge clk);
    model(1, 1'b0, 32'h40, 32'h0, 4'h0, erd, eerr, elat);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, lat);
    chk("midrst_mem", rd, erd);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int          d;
      bit          wr;
      logic [31:0] a, wd;
      logic [3:0]  sb;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 69) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) a = $urandom;
      wd = $urandom;
      sb = 4'($urandom);
      model(d, wr, a, wd, sb, erd, eerr, elat);
      xfer(d, wr, a, wd, sb, rd, err, lat);
      chk("rand_rdata", rd, erd);
      chk("rand_err", 32'(err), 32'(eerr));
      chk("rand_lat", 32'(lat), 32'(elat));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_wait_memory.md
# apb_wait_memory

Parametrised APB4 slave memory with per-direction programmable wait states, byte-strobe writes, address-range and alignment error reporting, and registered response signals. Sits behind an APB interconnect as a test/bring-up target for bus fabrics and masters. Generalises the fixed-width, zero-wait memory slave: configurable word width and depth, multi-cycle access timing and slave-error signalling.

## Interface

Parameters:
- ADDR_WIDTH, 32: width of s_paddr.
- DATA_WIDTH, 32: data width. Must be a multiple of 8, in the range 8..64.
- MEM_DEPTH, 64: number of DATA_WIDTH-bit words. Must be at least 2.
- RD_WAIT, 1: wait states inserted on reads, 0..15.
- WR_WAIT, 0: wait states inserted on writes, 0..15.
- ID, 0: 8-bit slave tag; used only with the configuration macro.

Ports:
- clk, in, 1: clock. All logic is rising-edge.
- rst, in, 1: reset. Asynchronous, active-high.
- s_psel, in, 1: APB select.
- s_penable, in, 1: APB enable (access phase).
- s_pwrite, in, 1: 1 = write, 0 = read.
- s_paddr, in, ADDR_WIDTH: byte address.
- s_pwdata, in, DATA_WIDTH: write data.
- s_pstrb, in, DATA_WIDTH/8: byte write strobes.
- s_prdata, out, DATA_WIDTH: read data. Registered.
- s_pready, out, 1: transfer complete. Registered.
- s_pslverr, out, 1: transfer error. Registered; valid only while s_pready=1.

## Operation

- Byte-lane count: BL = DATA_WIDTH/8.
- Word index: s_paddr >> log2(BL).
- Error condition (err), evaluated at the setup edge:
  - word index >= MEM_DEPTH, or
  - s_paddr[log2(BL)-1:0] != 0.
- FSM states: IDLE, WAIT, ACK. The wait counter cnt is 4 bits wide.
- IDLE:
  - On an edge with s_psel=1 and s_penable=0, latch direction, address and err.
  - N is RD_WAIT for a read or WR_WAIT for a write.
  - If N=0, go to ACK. Otherwise go to WAIT with cnt=N-1.
- WAIT:
  - If cnt=0, go to ACK; else decrement cnt.
- Entering ACK:
  - Load s_prdata with mem[index] for a read without err; otherwise 0.
  - Set s_pready=1 and s_pslverr=err.
- ACK:
  - s_pready=1 for exactly one cycle.
  - At the closing edge, a write commits if s_psel=1, s_penable=1 and err=0.
  - Commit rule: bytes with s_pstrb[i]=1 take s_pwdata[8i+:8]; other bytes are unchanged.
  - The FSM then returns to IDLE, and s_pready and s_pslverr return to 0.
- Write with s_pstrb=0: memory is unchanged; not an error.
- s_pstrb is ignored on reads.
- Abort: if s_psel=0 at any edge in WAIT or ACK, go to IDLE immediately. No write occurs, and s_pready and s_pslverr are cleared.
- Memory array contents are not reset and are undefined until written.

## Timing

- Reset values: s_pready=0, s_pslverr=0, s_prdata=0, state=IDLE, cnt=0.
- rst asserted mid-transfer aborts the transfer; no write occurs.
- Cycle numbering: setup cycle is T0, first access cycle is T1.
  - s_pready is high during cycle T1+N.
  - s_prdata and s_pslverr are valid in that same cycle.
  - A write takes effect at the edge ending T1+N.
- Back-to-back transfers: a setup in the cycle after ACK is accepted with no bubble.
- Read-after-write to the same word returns the new data.
- s_prdata holds its last value outside ACK. s_pslverr is 0 outside ACK.

## Configuration

- APB_WAIT_MEMORY_ID_TAG_EN defined:
  - On reads, s_prdata[DATA_WIDTH-1 -: 8] is replaced by ID[7:0]; the remaining bits are memory data.
  - An error read returns ID in the top byte and 0 elsewhere.
  - Supports identification of the responding slave in multi-slave fabrics.
- Macro not defined: s_prdata carries full memory data, and ID is unused.

## Test plan

- Reset, then idle: s_pready=0, s_pslverr=0, s_prdata=0 in every cycle.
- Defaults (DATA_WIDTH=32, RD_WAIT=1, WR_WAIT=0):
  - Write 0xDEADBEEF to 0x10 with s_pstrb=0xF; s_pready is high in T1.
  - Read 0x10; s_pready is high in T2 and s_prdata=0xDEADBEEF.
- Partial strobe:
  - Write 0x11223344 to 0x10 with s_pstrb=0x5, then read.
  - Returns 0xDE22BE44.
- Errors (MEM_DEPTH=64):
  - Read 0x100: s_pslverr=1 with s_pready, s_prdata=0.
  - Write 0x102: s_pslverr=1, memory unchanged.
- Abort: with RD_WAIT=3, drop s_psel in T2. s_pready never rises, and the FSM accepts a new setup in the next cycle.
- Macro defined with ID=0x5A:
  - Read of word 0x10 holding 0xDEADBEEF returns 0x5AADBEEF.
  - Without the macro, the same read returns 0xDEADBEEF.
